// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default geometry, clog2 helper and the timestamp
// record handed to the downstream FIFO.
package tdc_pkg;

    localparam int TDC_NUM      = 12;
    localparam int GROUP        = 4;
    localparam int TDC_COARSE_W = 16;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    localparam int TDC_WBIN = clog2(TDC_NUM + 1);

    typedef struct packed {
        logic [TDC_WBIN-1:0]     fine;
        logic [TDC_COARSE_W-1:0] coarse;
        logic                    bubble;
    } tdc_result_t;

endpackage

// File: rtl/therm_decoder_popcount4.sv
// Four-tap slice of the fine encoder: ones count plus a flag telling whether
// the slice is a clean thermometer fragment (ones packed from bit 0 upward).
module popcount4 (
    input  logic [3:0] bits_i,
    output logic [2:0] cnt_o,
    output logic       clean_o
);

    always_comb begin
        cnt_o = 3'(bits_i[0]) + 3'(bits_i[1]) + 3'(bits_i[2]) + 3'(bits_i[3]);
        unique case (bits_i)
            4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: clean_o = 1'b1;
            default:                                     clean_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/therm_decoder.sv
// Thermometer-to-timestamp decoder: tap-0 edge detect, grouped popcount with
// bubble check, coarse tagging and a single-entry valid/ready output slot.
module therm_decoder
    import tdc_pkg::*;
#(
    parameter  int NUM      = TDC_NUM,
    parameter  int COARSE_W = TDC_COARSE_W,
    localparam int WBIN     = clog2(NUM + 1)
) (
    input  logic                clk,
    input  logic                iRst,
    input  logic [NUM-1:0]      iTherm,
    input  logic                iEnable,
    input  logic                iReady,
    output logic                oValid,
    output logic [WBIN-1:0]     oFine,
    output logic [COARSE_W-1:0] oCoarse,
    output logic                oBubble,
    output logic [7:0]          oDropCnt
);

    localparam int NGRP = NUM / GROUP;

    logic [COARSE_W-1:0] coarse_q;

    logic [NUM-1:0]      therm_p0_q;
    logic [NUM-1:0]      prev_p0_q;
    logic [COARSE_W-1:0] coarse_p0_q;
    logic                en_p0_q;
    logic                hit_p0;
    logic                bub_p0;

    logic [2:0]          grp_cnt   [NGRP];
    logic [NGRP-1:0]     grp_clean;

    logic [2:0]          cnt_p1_q  [NGRP];
    logic [COARSE_W-1:0] coarse_p1_q;
    logic                bub_p1_q;
    logic                vld_p1_q;

    logic [WBIN-1:0]     fine_p2;

    logic                valid_q,  valid_d;
    logic [WBIN-1:0]     fine_q,   fine_d;
    logic [COARSE_W-1:0] coarse_o_q, coarse_o_d;
    logic                bub_q,    bub_d;
    logic [7:0]          drop_q,   drop_d;

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            coarse_q <= '0;
        end else begin
            coarse_q <= coarse_q + COARSE_W'(1);
        end
    end

    // ---- S0: sample word, keep previous word for the tap-0 edge ----
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            therm_p0_q  <= '0;
            prev_p0_q   <= '0;
            coarse_p0_q <= '0;
            en_p0_q     <= 1'b0;
        end else begin
            therm_p0_q  <= iTherm;
            prev_p0_q   <= therm_p0_q;
            coarse_p0_q <= coarse_q;
            en_p0_q     <= iEnable;
        end
    end

    assign hit_p0 = en_p0_q & therm_p0_q[0] & ~prev_p0_q[0];

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        popcount4 u_pc (
            .bits_i  (therm_p0_q[GROUP*g +: GROUP]),
            .cnt_o   (grp_cnt[g]),
            .clean_o (grp_clean[g])
        );
    end

    // A one at the bottom of a group with a zero at the top of the group
    // below is the only bubble the per-group clean flags cannot see.
    always_comb begin
        bub_p0 = ~(&grp_clean);
        for (int g = 1; g < NGRP; g++) begin
            if (therm_p0_q[GROUP*g] && !therm_p0_q[GROUP*g-1]) begin
                bub_p0 = 1'b1;
            end
        end
    end

    // ---- S1: group counts, bubble flag and coarse tag for hits ----
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            for (int g = 0; g < NGRP; g++) begin
                cnt_p1_q[g] <= '0;
            end
            coarse_p1_q <= '0;
            bub_p1_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
        end else begin
            vld_p1_q <= hit_p0;
            if (hit_p0) begin
                for (int g = 0; g < NGRP; g++) begin
                    cnt_p1_q[g] <= grp_cnt[g];
                end
                coarse_p1_q <= coarse_p0_q;
                bub_p1_q    <= bub_p0;
            end
        end
    end

    // ---- S2: sum group counts into the fine value ----
    always_comb begin
        fine_p2 = '0;
        for (int g = 0; g < NGRP; g++) begin
            fine_p2 = fine_p2 + WBIN'(cnt_p1_q[g]);
        end
    end

    always_comb begin
        valid_d    = valid_q;
        fine_d     = fine_q;
        coarse_o_d = coarse_o_q;
        bub_d      = bub_q;
        drop_d     = drop_q;
        if (vld_p1_q && (!valid_q || iReady)) begin
            valid_d    = 1'b1;
            fine_d     = fine_p2;
            coarse_o_d = coarse_p1_q;
            bub_d      = bub_p1_q;
        end else if (vld_p1_q) begin
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    // ---- Output slot ----
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            valid_q    <= 1'b0;
            fine_q     <= '0;
            coarse_o_q <= '0;
            bub_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            fine_q     <= fine_d;
            coarse_o_q <= coarse_o_d;
            bub_q      <= bub_d;
            drop_q     <= drop_d;
        end
    end

    assign oValid   = valid_q;
    assign oFine    = fine_q;
    assign oCoarse  = coarse_o_q;
    assign oBubble  = bub_q;
    assign oDropCnt = drop_q;

endmodule

// File: tb/tb_therm_decoder.sv
// Directed bench for therm_decoder (NUM=12): latency, encoding, bubbles,
// backpressure, enable gating and reset behaviour.
module tb_therm_decoder;

    localparam int NUM      = 12;
    localparam int COARSE_W = 16;
    localparam int WBIN     = 4;

    logic                clk;
    logic                iRst;
    logic [NUM-1:0]      iTherm;
    logic                iEnable;
    logic                iReady;
    logic                oValid;
    logic [WBIN-1:0]     oFine;
    logic [COARSE_W-1:0] oCoarse;
    logic                oBubble;
    logic [7:0]          oDropCnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    therm_decoder #(
        .NUM      (NUM),
        .COARSE_W (COARSE_W)
    ) dut (
        .clk      (clk),
        .iRst     (iRst),
        .iTherm   (iTherm),
        .iEnable  (iEnable),
        .iReady   (iReady),
        .oValid   (oValid),
        .oFine    (oFine),
        .oCoarse  (oCoarse),
        .oBubble  (oBubble),
        .oDropCnt (oDropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Re-arm word, then the hit word, then three cycles to the output slot.
    task automatic hit_run(input string tag, input logic [NUM-1:0] word,
                           input int exp_fine, input int exp_bub);
        int t;
        iTherm = '0;
        step();
        t      = cyc;
        iTherm = word;
        step();
        iTherm = '0;
        chk({tag, "_valid_t1"}, 32'(oValid), 32'd0);
        step();
        chk({tag, "_valid_t2"}, 32'(oValid), 32'd0);
        step();
        chk({tag, "_valid_t3"}, 32'(oValid), 32'd1);
        chk({tag, "_fine"},     32'(oFine), 32'(exp_fine));
        chk({tag, "_bubble"},   32'(oBubble), 32'(exp_bub));
        chk({tag, "_coarse"},   32'(oCoarse), 32'(t));
        step();
        chk({tag, "_valid_after"}, 32'(oValid), 32'd0);
    endtask

    initial begin
        int t;
        int nvalid;

        iRst    = 1'b1;
        iTherm  = '0;
        iEnable = 1'b1;
        iReady  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        iRst = 1'b0;
        cyc  = 0;

        chk("rst_valid",  32'(oValid), 32'd0);
        chk("rst_fine",   32'(oFine), 32'd0);
        chk("rst_coarse", 32'(oCoarse), 32'd0);
        chk("rst_bubble", 32'(oBubble), 32'd0);
        chk("rst_drop",   32'(oDropCnt), 32'd0);

        // Basic conversion: 0, 0, 0x01F, then 0xFFF held.
        iTherm = '0;
        step();
        step();
        t      = cyc;
        iTherm = 12'h01F;
        step();
        iTherm = 12'hFFF;
        chk("basic_valid_t1", 32'(oValid), 32'd0);
        step();
        chk("basic_valid_t2", 32'(oValid), 32'd0);
        step();
        chk("basic_valid_t3", 32'(oValid), 32'd1);
        chk("basic_fine",     32'(oFine), 32'd5);
        chk("basic_bubble",   32'(oBubble), 32'd0);
        chk("basic_coarse",   32'(oCoarse), 32'(t));
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (oValid) nvalid++;
        end
        chk("basic_held_level_results", 32'(nvalid), 32'd0);

        hit_run("bubble", 12'h0DF, 7, 1);
        hit_run("allones", 12'hFFF, 12, 0);
        hit_run("single", 12'h001, 1, 0);

        // Backpressure: first result held, second dropped.
        iReady = 1'b0;
        iTherm = '0;
        step();
        t      = cyc;
        iTherm = 12'h003;
        step();
        iTherm = '0;
        step();
        step();
        chk("bp_first_valid", 32'(oValid), 32'd1);
        chk("bp_first_fine",  32'(oFine), 32'd2);
        step();
        iTherm = 12'h007;
        step();
        iTherm = '0;
        chk("bp_hold_fine_a", 32'(oFine), 32'd2);
        step();
        chk("bp_hold_valid",  32'(oValid), 32'd1);
        chk("bp_drop_before", 32'(oDropCnt), 32'd0);
        step();
        chk("bp_hold_fine_b",   32'(oFine), 32'd2);
        chk("bp_hold_coarse",   32'(oCoarse), 32'(t));
        chk("bp_hold_bubble",   32'(oBubble), 32'd0);
        chk("bp_drop_after",    32'(oDropCnt), 32'd1);
        chk("bp_valid_pre_rdy", 32'(oValid), 32'd1);
        iReady = 1'b1;
        step();
        chk("bp_valid_after_xfer", 32'(oValid), 32'd0);
        chk("bp_drop_kept",        32'(oDropCnt), 32'd1);

        // Arrival in the same cycle the held result is accepted.
        iReady = 1'b0;
        iTherm = '0;
        step();
        iTherm = 12'h00F;
        step();
        iTherm = '0;
        step();
        step();
        chk("sim_first_fine", 32'(oFine), 32'd4);
        step();
        t      = cyc;
        iTherm = 12'h03F;
        step();
        iTherm = '0;
        step();
        chk("sim_still_first", 32'(oFine), 32'd4);
        iReady = 1'b1;
        step();
        chk("sim_valid",  32'(oValid), 32'd1);
        chk("sim_fine",   32'(oFine), 32'd6);
        chk("sim_coarse", 32'(oCoarse), 32'(t));
        chk("sim_drop",   32'(oDropCnt), 32'd1);
        step();
        chk("sim_valid_after", 32'(oValid), 32'd0);

        // Enable low during the rising edge: no result, level does not re-trigger.
        iEnable = 1'b0;
        iTherm  = '0;
        step();
        iTherm = 12'h00F;
        step();
        iEnable = 1'b1;
        nvalid  = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (oValid) nvalid++;
        end
        chk("enable_no_result", 32'(nvalid), 32'd0);

        // Reset one cycle after a detected hit.
        iTherm = '0;
        step();
        iTherm = 12'h0FF;
        step();
        iRst = 1'b1;
        #1;
        chk("arst_valid",  32'(oValid), 32'd0);
        chk("arst_fine",   32'(oFine), 32'd0);
        chk("arst_coarse", 32'(oCoarse), 32'd0);
        chk("arst_bubble", 32'(oBubble), 32'd0);
        chk("arst_drop",   32'(oDropCnt), 32'd0);
        iTherm = 12'h001;
        @(posedge clk);
        #1;
        iRst = 1'b0;
        cyc  = 0;
        nvalid = 0;
        step();
        if (oValid) nvalid++;
        step();
        if (oValid) nvalid++;
        chk("arst_no_inflight", 32'(nvalid), 32'd0);
        step();
        chk("post_rst_hit_valid",  32'(oValid), 32'd1);
        chk("post_rst_hit_fine",   32'(oFine), 32'd1);
        chk("post_rst_hit_coarse", 32'(oCoarse), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (oValid) nvalid++;
        end
        chk("post_rst_single_result", 32'(nvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
